// File: rtl/raycast_pkg.sv
// Shared types and constants for the column renderer: FSM states,
// descriptor field layout and the RGB565 wall palette.
package raycast_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  localparam int unsigned DESC_W       = 38;
  localparam int unsigned HCOUNT_LSB   = 29;
  localparam int unsigned HCOUNT_W     = 9;
  localparam int unsigned LINE_H_LSB   = 21;
  localparam int unsigned LINE_H_W     = 8;
  localparam int unsigned WALL_TYPE_BIT = 20;
  localparam int unsigned MAP_LSB      = 16;
  localparam int unsigned MAP_W        = 4;
  localparam int unsigned WALL_X_LSB   = 0;
  localparam int unsigned WALL_X_W     = 16;

  localparam logic [15:0] SHADE_MASK = 16'h7BEF;

  localparam logic [15:0] PALETTE [16] = '{
    16'hFFFF, 16'h0000, 16'hF800, 16'h07E0,
    16'h001F, 16'hFFE0, 16'h07FF, 16'hF81F,
    16'h8410, 16'hC618, 16'hFC00, 16'h8000,
    16'h0400, 16'h0010, 16'h8010, 16'h0410
  };

endpackage

// File: rtl/column_shader.sv
// Combinational ceiling / wall / floor colour select for one row.
// Wall darkening for wallType = 1 is built only when SHADING_EN is defined.
module column_shader
  import raycast_pkg::*;
#(
  parameter int unsigned ROW_W       = 8,
  parameter logic [15:0] CEIL_COLOR  = 16'hFFFF,
  parameter logic [15:0] FLOOR_COLOR = 16'h8410
) (
  input  logic [ROW_W-1:0] row,
  input  logic [ROW_W-1:0] draw_start,
  input  logic [ROW_W-1:0] draw_end,
  input  logic [MAP_W-1:0] map_data,
  input  logic             wall_type,
  output logic [15:0]      pixel
);

  logic [15:0] base_color;
  logic [15:0] wall_color;

  assign base_color = PALETTE[map_data];

`ifdef SHADING_EN
  assign wall_color = wall_type ? ((base_color >> 1) & SHADE_MASK) : base_color;
`else
  logic unused_wall_type;
  assign unused_wall_type = wall_type;
  assign wall_color       = base_color;
`endif

  always_comb begin
    pixel = FLOOR_COLOR;
    if (row < draw_start) begin
      pixel = CEIL_COLOR;
    end else if (row < draw_end) begin
      pixel = wall_color;
    end
  end

endmodule

// File: rtl/column_renderer.sv
// Expands one column descriptor into SCREEN_HEIGHT frame-buffer pixel beats.
// Optional build macro: SHADING_EN (darkens wallType = 1 wall pixels).
module column_renderer
  import raycast_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = 320,
  parameter int unsigned SCREEN_HEIGHT = 180,
  parameter logic [15:0] CEIL_COLOR    = 16'hFFFF,
  parameter logic [15:0] FLOOR_COLOR   = 16'h8410,
  localparam int unsigned ADDR_W       = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic              dda_fifo_tvalid_in,
  input  logic [DESC_W-1:0] dda_fifo_tdata_in,
  input  logic              dda_fifo_tlast_in,
  output logic              renderer_tready_out,
  input  logic              frame_buff_ready_in,
  output logic              ray_valid_out,
  output logic [ADDR_W-1:0] ray_address_out,
  output logic [15:0]       ray_pixel_out,
  output logic              ray_last_pixel_out
);

  localparam int unsigned ROW_W  = $clog2(SCREEN_HEIGHT + 1);
  localparam int unsigned HALF_H = SCREEN_HEIGHT / 2;

  state_t state, next_state;

  logic [ROW_W-1:0]    row_cnt;
  logic [HCOUNT_W-1:0] hcount_q;
  logic [MAP_W-1:0]    map_q;
  logic                wall_type_q;
  logic                last_q;
  logic [ROW_W-1:0]    draw_start_q, draw_end_q;
  logic [ROW_W-1:0]    draw_start_d, draw_end_d;
  logic [LINE_H_W-1:0] half;
  logic [15:0]         shade_pixel;
  logic                handshake, accept, col_done, emit;

  logic unused_wall_x;
  assign unused_wall_x = ^dda_fifo_tdata_in[WALL_X_LSB +: WALL_X_W];

  assign handshake = dda_fifo_tvalid_in & renderer_tready_out;
  assign accept    = ray_valid_out & frame_buff_ready_in;
  // row_cnt is the next row to emit, so it equals SCREEN_HEIGHT while the final row is on the bus
  assign col_done  = accept && (row_cnt == ROW_W'(SCREEN_HEIGHT));
  assign emit      = (state == DRAW) && ((row_cnt == '0) || (accept && !col_done));

  always_comb begin
    half         = dda_fifo_tdata_in[LINE_H_LSB +: LINE_H_W] >> 1;
    draw_start_d = '0;
    draw_end_d   = ROW_W'(SCREEN_HEIGHT);
    if (32'(half) < HALF_H) begin
      draw_start_d = ROW_W'(HALF_H - 32'(half));
      draw_end_d   = ROW_W'(HALF_H + 32'(half));
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (handshake) next_state = DRAW;
      DRAW:    if (col_done)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  column_shader #(
    .ROW_W      (ROW_W),
    .CEIL_COLOR (CEIL_COLOR),
    .FLOOR_COLOR(FLOOR_COLOR)
  ) u_shader (
    .row       (row_cnt),
    .draw_start(draw_start_q),
    .draw_end  (draw_end_q),
    .map_data  (map_q),
    .wall_type (wall_type_q),
    .pixel     (shade_pixel)
  );

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state               <= IDLE;
      renderer_tready_out <= 1'b0;
      ray_valid_out       <= 1'b0;
      ray_last_pixel_out  <= 1'b0;
      ray_address_out     <= '0;
      ray_pixel_out       <= '0;
      row_cnt             <= '0;
      hcount_q            <= '0;
      map_q               <= '0;
      wall_type_q         <= 1'b0;
      last_q              <= 1'b0;
      draw_start_q        <= '0;
      draw_end_q          <= '0;
    end else begin
      state               <= next_state;
      renderer_tready_out <= (next_state == IDLE);
      if (handshake) begin
        hcount_q     <= dda_fifo_tdata_in[HCOUNT_LSB +: HCOUNT_W];
        map_q        <= dda_fifo_tdata_in[MAP_LSB +: MAP_W];
        wall_type_q  <= dda_fifo_tdata_in[WALL_TYPE_BIT];
        last_q       <= dda_fifo_tlast_in;
        draw_start_q <= draw_start_d;
        draw_end_q   <= draw_end_d;
        row_cnt      <= '0;
      end
      if (emit) begin
        ray_valid_out      <= 1'b1;
        ray_pixel_out      <= shade_pixel;
        ray_address_out    <= (row_cnt == '0) ? ADDR_W'(hcount_q)
                                              : ray_address_out + ADDR_W'(SCREEN_WIDTH);
        ray_last_pixel_out <= last_q && (row_cnt == ROW_W'(SCREEN_HEIGHT - 1));
        row_cnt            <= row_cnt + 1'b1;
      end else if (col_done) begin
        ray_valid_out      <= 1'b0;
        ray_last_pixel_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_column_renderer.sv
// Directed self-checking bench for column_renderer (default parameters).
module tb_column_renderer;

  localparam int H = 180;
  localparam int W = 320;
`ifdef SHADING_EN
  localparam bit SHADE_ON = 1'b1;
`else
  localparam bit SHADE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tvalid;
  logic [37:0] tdata;
  logic        tlast;
  logic        tready;
  logic        fb_ready;
  logic        ray_valid;
  logic [15:0] ray_addr;
  logic [15:0] ray_pixel;
  logic        ray_last;

  int checks = 0;
  int errors = 0;

  logic [15:0] pal [16] = '{
    16'hFFFF, 16'h0000, 16'hF800, 16'h07E0,
    16'h001F, 16'hFFE0, 16'h07FF, 16'hF81F,
    16'h8410, 16'hC618, 16'hFC00, 16'h8000,
    16'h0400, 16'h0010, 16'h8010, 16'h0410
  };

  logic [15:0] pix_q  [H];
  logic [15:0] addr_q [H];
  logic        last_q [H];

  always #5 clk = ~clk;

  column_renderer dut (
    .pixel_clk_in       (clk),
    .rst_in             (rst_n),
    .dda_fifo_tvalid_in (tvalid),
    .dda_fifo_tdata_in  (tdata),
    .dda_fifo_tlast_in  (tlast),
    .renderer_tready_out(tready),
    .frame_buff_ready_in(fb_ready),
    .ray_valid_out      (ray_valid),
    .ray_address_out    (ray_addr),
    .ray_pixel_out      (ray_pixel),
    .ray_last_pixel_out (ray_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int lh, input int wt, input int md, input int row);
    int half, ds, de;
    logic [15:0] c;
    half = lh / 2;
    if (half >= H / 2) begin ds = 0; de = H; end
    else begin ds = H / 2 - half; de = H / 2 + half; end
    if (row < ds) return 16'hFFFF;
    if (row >= de) return 16'h8410;
    c = pal[md];
    if (SHADE_ON && wt != 0) c = (c >> 1) & 16'h7BEF;
    return c;
  endfunction

  task automatic run_column(input int hc, input int lh, input int wt, input int md,
                            input int last, input int stall_row, input int abort_row);
    int row_idx = 0, stall_left = 3, guard = 0, wait_cnt = 0, held = 0;
    bit started = 0;
    logic [15:0] exp_addr;
    while (!tready && guard < 50) begin @(negedge clk); guard++; end
    check("tready_before_desc", tready, 1);
    tvalid = 1'b1;
    tdata  = {hc[8:0], lh[7:0], wt[0], md[3:0], 16'hABCD};
    tlast  = last[0];
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    check("tready_low_in_draw", tready, 0);
    guard = 0;
    while (row_idx < H && guard < 2000) begin
      guard++;
      if (abort_row >= 0 && ray_valid && row_idx == abort_row) begin
        rst_n = 1'b0;
        #1;
        check("abort_valid", ray_valid, 0);
        check("abort_addr", ray_addr, 0);
        check("abort_pixel", ray_pixel, 0);
        check("abort_last", ray_last, 0);
        check("abort_tready", tready, 0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        fb_ready = 1'b1;
        @(negedge clk);
        check("abort_tready_after", tready, 1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("abort_no_beats", ray_valid, 0);
        end
        return;
      end
      if (ray_valid) started = 1;
      else if (!started) wait_cnt++;
      if (ray_valid && row_idx == stall_row && stall_left > 0) begin
        fb_ready = 1'b0;
        stall_left--;
      end else begin
        fb_ready = 1'b1;
      end
      if (ray_valid) begin
        exp_addr = 16'(hc + W * row_idx);
        if (row_idx == stall_row) held++;
        check($sformatf("pixel_row%0d", row_idx), ray_pixel, exp_pix(lh, wt, md, row_idx));
        check($sformatf("addr_row%0d", row_idx), ray_addr, exp_addr);
        check($sformatf("last_row%0d", row_idx), ray_last, (last != 0 && row_idx == H - 1));
        pix_q[row_idx]  = ray_pixel;
        addr_q[row_idx] = ray_addr;
        last_q[row_idx] = ray_last;
        if (fb_ready) row_idx++;
      end else if (started) begin
        check("contiguous_beats", ray_valid, 1);
      end
      @(negedge clk);
    end
    fb_ready = 1'b1;
    check("beat_count", row_idx, H);
    check("first_beat_latency", wait_cnt, 1);
    check("valid_low_after_col", ray_valid, 0);
    check("tready_after_col", tready, 1);
    if (stall_row >= 0) check("stall_held_cycles", held, 4);
  endtask

  initial begin
    rst_n    = 1'b0;
    tvalid   = 1'b0;
    tdata    = '0;
    tlast    = 1'b0;
    fb_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tready", tready, 0);
    check("rst_valid", ray_valid, 0);
    check("rst_addr", ray_addr, 0);
    check("rst_pixel", ray_pixel, 0);
    check("rst_last", ray_last, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_after_rst", tready, 1);

    // hcount 5, lineHeight 60, black wall
    run_column(5, 60, 0, 1, 0, -1, -1);
    check("t1_row0", pix_q[0], 16'hFFFF);
    check("t1_row59", pix_q[59], 16'hFFFF);
    check("t1_row60", pix_q[60], 16'h0000);
    check("t1_row119", pix_q[119], 16'h0000);
    check("t1_row120", pix_q[120], 16'h8410);
    check("t1_row179", pix_q[179], 16'h8410);
    check("t1_addr0", addr_q[0], 16'd5);
    check("t1_addr1", addr_q[1], 16'd325);
    check("t1_addr179", addr_q[179], 16'd57285);

    // full-height wall and empty wall
    run_column(7, 255, 0, 2, 0, -1, -1);
    check("t2_row0", pix_q[0], 16'hF800);
    check("t2_row179", pix_q[179], 16'hF800);
    run_column(9, 0, 0, 3, 0, -1, -1);
    check("t3_row89", pix_q[89], 16'hFFFF);
    check("t3_row90", pix_q[90], 16'h8410);

    // half one below the clamp threshold, and exactly at it
    run_column(11, 179, 0, 4, 0, -1, -1);
    check("t4_row0", pix_q[0], 16'hFFFF);
    check("t4_row1", pix_q[1], 16'h001F);
    check("t4_row179", pix_q[179], 16'h8410);
    run_column(11, 180, 0, 4, 0, -1, -1);
    check("t4b_row0", pix_q[0], 16'h001F);

    // backpressure at row 10
    run_column(12, 100, 0, 6, 0, 10, -1);
    check("t5_addr10", addr_q[10], 16'd3212);

    // two columns, second carries tlast
    run_column(20, 40, 0, 7, 0, -1, -1);
    check("t6_first_last", last_q[179], 0);
    run_column(21, 40, 0, 7, 1, -1, -1);
    check("t6_second_last", last_q[179], 1);
    check("t6_second_addr", addr_q[179], 16'd57301);

    // wallType with white palette entry
    run_column(30, 100, 1, 0, 0, -1, -1);
    check("t7_shade_row90", pix_q[90], SHADE_ON ? 16'h7BEF : 16'hFFFF);
    check("t7_ceil_row0", pix_q[0], 16'hFFFF);
    run_column(31, 100, 0, 0, 0, -1, -1);
    check("t7_noshade_row90", pix_q[90], 16'hFFFF);

    // reset mid-column, then a fresh column
    run_column(40, 80, 0, 5, 0, -1, 50);
    run_column(41, 80, 0, 5, 0, -1, -1);
    check("t8_addr0", addr_q[0], 16'd41);
    check("t8_row90", pix_q[90], 16'hFFE0);

    // hcount beyond screen width
    run_column(400, 20, 0, 8, 0, -1, -1);
    check("t9_addr179", addr_q[179], 16'd57680);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
